// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and controller state type.
// Used by sha256_round_ctrl and, with SHA_K_ROM_EN, by sha256_k_rom.
package sha256_pkg;

    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] LAST_MSG_W = 6'(MSG_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value, consumed by the H register init logic on init_iv.
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[i_idx].
// Instantiated by sha256_round_ctrl only when SHA_K_ROM_EN is defined.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_idx,
    output logic [31:0] o_k
);

    assign o_k = K[i_idx];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, 64-round strobes, hash update.
// Optional macro SHA_K_ROM_EN adds an internal K ROM and the k_o output.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        blk_valid,
    input  logic        blk_first,
    input  logic        blk_last,
    output logic        blk_ready,
    output logic        busy,
    output logic        msg_ld,
    output logic        init_iv,
    output logic        ld_work,
    output logic        round_en,
    output logic [5:0]  round_idx,
    output logic        w_sel,
    output logic        hash_upd,
    output logic        digest_valid
`ifdef SHA_K_ROM_EN
    ,
    output logic [31:0] k_o
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic       r_first;
    logic       r_last;
    logic [5:0] r_idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && blk_valid) begin
                r_first <= blk_first;
                r_last  <= blk_last;
            end
            // Counter only advances in ROUND and is parked at 0 everywhere else.
            if (r_state == S_ROUND && r_idx != LAST_ROUND) begin
                r_idx <= r_idx + 6'd1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        blk_ready    = 1'b0;
        msg_ld       = 1'b0;
        init_iv      = 1'b0;
        ld_work      = 1'b0;
        round_en     = 1'b0;
        w_sel        = 1'b0;
        hash_upd     = 1'b0;
        digest_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                msg_ld  = 1'b1;
                init_iv = r_first;
                w_next  = S_LOAD;
            end
            S_LOAD: begin
                ld_work = 1'b1;
                w_next  = S_ROUND;
            end
            S_ROUND: begin
                round_en = 1'b1;
                w_sel    = (r_idx <= LAST_MSG_W);
                if (r_idx == LAST_ROUND) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                hash_upd = 1'b1;
                w_next   = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy      = ~blk_ready;
    assign round_idx = r_idx;

`ifdef SHA_K_ROM_EN
    logic [31:0] w_k;

    sha256_k_rom u_k_rom (
        .i_idx (r_idx),
        .o_k   (w_k)
    );

    // r_idx idles at 0, so the ROM output must be gated to keep k_o at 0 outside ROUND.
    assign k_o = (r_state == S_ROUND) ? w_k : 32'h0;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed testbench for sha256_round_ctrl; checks every cycle against a timing table.
// Define SHA_K_ROM_EN to also exercise the k_o constant ROM.
module tb_sha256_round_ctrl;

    logic        CLK;
    logic        RST;
    logic        blk_valid;
    logic        blk_first;
    logic        blk_last;
    logic        blk_ready;
    logic        busy;
    logic        msg_ld;
    logic        init_iv;
    logic        ld_work;
    logic        round_en;
    logic [5:0]  round_idx;
    logic        w_sel;
    logic        hash_upd;
    logic        digest_valid;
`ifdef SHA_K_ROM_EN
    logic [31:0] k_o;
`endif

    int total;
    int bad;

    logic [14:0] obs;

    sha256_round_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .busy         (busy),
        .msg_ld       (msg_ld),
        .init_iv      (init_iv),
        .ld_work      (ld_work),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .w_sel        (w_sel),
        .hash_upd     (hash_upd),
        .digest_valid (digest_valid)
`ifdef SHA_K_ROM_EN
        ,
        .k_o          (k_o)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign obs = {blk_ready, busy, msg_ld, init_iv, ld_work, round_en, w_sel,
                  hash_upd, digest_valid, round_idx};

    // Expected outputs c cycles after the accept edge (c<=0 means still idle before accept).
    function automatic logic [14:0] exp_vec(input int c, input logic f, input logic l);
        logic       rdy;
        logic       re;
        logic [5:0] ix;
        rdy = (c <= 0) || (c >= (l ? 69 : 68));
        re  = (c >= 3) && (c <= 66);
        ix  = re ? 6'(c - 3) : 6'd0;
        return {rdy, ~rdy, (c == 1), (c == 1) && f, (c == 2), re,
                (c >= 3) && (c <= 18), (c == 67), (c == 68) && l, ix};
    endfunction

    localparam logic [14:0] IDLE_VEC = {1'b1, 14'b0};

    task automatic test_reset();
        RST       = 1'b1;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (obs !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL reset_vec obs=%h exp=%h", obs, IDLE_VEC);
        end
`ifdef SHA_K_ROM_EN
        total++;
        if (k_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_k obs=%h exp=0", k_o);
        end
`endif
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (obs !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL post_reset_idle obs=%h exp=%h", obs, IDLE_VEC);
        end
    endtask

    task automatic test_single_block();
        int n_re;
        int n_ws;
        n_re = 0;
        n_ws = 0;
        @(negedge CLK);
        total++;
        if (blk_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_ready_pre obs=%b exp=1", blk_ready);
        end
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge CLK);
        #1 blk_valid = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b1, 1'b1)) begin
                bad++;
                $display("[TB] FAIL single c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b1, 1'b1));
            end
            n_re += int'(round_en);
            n_ws += int'(w_sel);
        end
        total++;
        if (n_re !== 64) begin
            bad++;
            $display("[TB] FAIL single_round_en_count obs=%0d exp=64", n_re);
        end
        total++;
        if (n_ws !== 16) begin
            bad++;
            $display("[TB] FAIL single_w_sel_count obs=%0d exp=16", n_ws);
        end
    endtask

`ifdef SHA_K_ROM_EN
    task automatic test_k_rom();
        @(negedge CLK);
        total++;
        if (k_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL k_idle obs=%h exp=0", k_o);
        end
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge CLK);
        #1 blk_valid = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            @(negedge CLK);
            if (c == 3) begin
                total++;
                if (k_o !== 32'h428a2f98) begin
                    bad++;
                    $display("[TB] FAIL k_idx0 obs=%h exp=428a2f98", k_o);
                end
            end else if (c == 4) begin
                total++;
                if (k_o !== 32'h71374491) begin
                    bad++;
                    $display("[TB] FAIL k_idx1 obs=%h exp=71374491", k_o);
                end
            end else if (c == 66) begin
                total++;
                if (k_o !== 32'hc67178f2) begin
                    bad++;
                    $display("[TB] FAIL k_idx63 obs=%h exp=c67178f2", k_o);
                end
            end else if (c == 67) begin
                total++;
                if (k_o !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL k_update obs=%h exp=0", k_o);
                end
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        int n_iv;
        int n_dv;
        n_iv = 0;
        n_dv = 0;
        @(negedge CLK);
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b0;
        @(posedge CLK);
        #1;
        blk_first = 1'b0;
        blk_last  = 1'b1;
        // blk_valid stays high so block 2 must be taken on the first ready cycle.
        for (int c = 1; c <= 68; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b1, 1'b0)) begin
                bad++;
                $display("[TB] FAIL b2b_blk1 c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b1, 1'b0));
            end
            n_iv += int'(init_iv);
            n_dv += int'(digest_valid);
        end
        total++;
        if (n_dv !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_blk1_digest obs=%0d exp=0", n_dv);
        end
        for (int c = 1; c <= 69; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b0, 1'b1)) begin
                bad++;
                $display("[TB] FAIL b2b_blk2 c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b0, 1'b1));
            end
            n_iv += int'(init_iv);
            n_dv += int'(digest_valid);
            if (c == 1) blk_valid = 1'b0;
        end
        total++;
        if (n_iv !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_init_iv_count obs=%0d exp=1", n_iv);
        end
        total++;
        if (n_dv !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_digest_count obs=%0d exp=1", n_dv);
        end
    endtask

    task automatic test_busy_ignore();
        @(negedge CLK);
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge CLK);
        #1 blk_valid = 1'b0;
        for (int c = 1; c <= 71; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b1, 1'b1)) begin
                bad++;
                $display("[TB] FAIL busy_ignore c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b1, 1'b1));
            end
            if (c == 23) begin
                blk_valid = 1'b1;
                blk_first = 1'b0;
                blk_last  = 1'b0;
            end else if (c == 24) begin
                blk_valid = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge CLK);
        #1 blk_valid = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b1, 1'b1)) begin
                bad++;
                $display("[TB] FAIL midrst_pre c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b1, 1'b1));
            end
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if (obs !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL midrst_async obs=%h exp=%h", obs, IDLE_VEC);
        end
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if (obs !== IDLE_VEC) begin
            bad++;
            $display("[TB] FAIL midrst_held obs=%h exp=%h", obs, IDLE_VEC);
        end
        RST       = 1'b0;
        blk_valid = 1'b1;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge CLK);
        #1 blk_valid = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            @(negedge CLK);
            total++;
            if (obs !== exp_vec(c, 1'b1, 1'b1)) begin
                bad++;
                $display("[TB] FAIL midrst_post c=%0d obs=%h exp=%h", c, obs, exp_vec(c, 1'b1, 1'b1));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        $display("[TB] start");
        test_reset();
        test_single_block();
`ifdef SHA_K_ROM_EN
        test_k_rom();
`endif
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
